// File: rtl/demux_pkg.sv
// demux_pkg: shared widths and channel index type for the demux router
package demux_pkg;
  localparam int WIDTH = 16;
  localparam int NCH = 4;
  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] chan_idx_t;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with valid flag; refill wins over drain
module demux_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      if (load) q <= data;
      valid <= load | (valid & ~drain);
    end
  end
endmodule

// File: rtl/sixteen_one_by_four_demux_router.sv
// sixteen_one_by_four_demux_router: routes one input stream to four buffered channels by select or round-robin
module sixteen_one_by_four_demux_router
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 auto_mode,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [1:0]           rr_ptr,
  output logic [15:0]          xfer_count
);
  chan_idx_t target;
  logic accept;
  assign target = auto_mode ? rr_ptr : in_sel;
  assign in_ready = ~out_valid[target] | out_ready[target];
  assign accept = in_valid & in_ready;
  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .load(accept && target == chan_idx_t'(k)),
      .data(in_data),
      .drain(out_ready[k]),
      .valid(out_valid[k]),
      .q(out_data[k*WIDTH +: WIDTH])
    );
  end
  // rr_ptr only advances on an actual accept, so a blocked target stalls auto mode in order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      xfer_count <= '0;
    end else begin
      if (accept && auto_mode) rr_ptr <= rr_ptr + 2'd1;
      if (accept) xfer_count <= xfer_count + 16'd1;
    end
  end
endmodule
